wb_trace_fifo: RTL and testbench
================================

Name: wb_trace_fifo

Overview:
- Commit-trace buffer for Pipe_CPU, sitting directly downstream of the MEM/WB boundary.
- Captures every architectural register-file write and data-memory write, time-stamps each one with a free-running cycle counter, and queues it in a FIFO.
- A bench monitor or debug port drains the queue through a valid/ready handshake.
- Replaces fixed-cycle register/memory dumps with an ordered, cycle-accurate write log.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- CYC_W, 16, cycle-stamp width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  capture enable.
- clr_i  in  1  synchronous clear of overflow_o and drop_cnt_o.
- rf_we_i  in  1  WB-stage register write strobe.
- rf_addr_i  in  5  WB destination register.
- rf_data_i  in  32  WB write data.
- dm_we_i  in  1  MEM-stage data-memory write strobe.
- dm_addr_i  in  32  MEM byte address.
- dm_data_i  in  32  MEM store data.
- tr_valid_o  out  1  head entry valid.
- tr_ready_i  in  1  consumer accepts head.
- tr_kind_o  out  1  0 = register write, 1 = memory write.
- tr_addr_o  out  32  register number (zero-extended) or memory address.
- tr_data_o  out  32  written value.
- tr_cycle_o  out  CYC_W  cycle stamp.
- count_o  out  log2(DEPTH)+1  occupancy.
- overflow_o  out  1  sticky drop flag.
- drop_cnt_o  out  8  dropped events, saturating at 255.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset (asynchronous, no clock edge needed):
  - pointers, count_o, cycle counter, overflow_o and drop_cnt_o all 0.
  - tr_valid_o = 0.
  - Stored entries are discarded.
- Cycle counter: 0 in the first cycle after rst_i deasserts; +1 every clock; wraps at 2^CYC_W; runs regardless of en_i.
- RF event: en_i & rf_we_i & (rf_addr_i != 0). Writes to r0 are never logged.
- DM event: en_i & dm_we_i.
- Stamp: both event kinds carry the counter value of the cycle in which the strobe is sampled.
- Ordering: when both events occur in the same cycle, the RF entry (older instruction, in WB) is enqueued before the DM entry (younger instruction, in MEM). Both carry the same stamp.
- Pop: occurs on a rising edge when tr_valid_o & tr_ready_i. tr_ready_i while empty has no effect.
- Free slots: computed as DEPTH − count_o + (pop this cycle ? 1 : 0).
- Allocation: events take free slots in order, RF first. Events that do not fit are dropped:
  - overflow_o is set.
  - drop_cnt_o increases by the number dropped (0–2), saturating at 255.
- clr_i: zeroes overflow_o and drop_cnt_o. If a drop occurs in the same cycle, the drop wins: overflow_o = 1 and drop_cnt_o = number dropped this cycle.
- Latency: an event sampled at edge N is visible on tr_valid_o in the cycle after edge N.
- Output timing: first-word-fall-through. Head fields are driven from storage and are all 0 whenever tr_valid_o = 0.
- Occupancy:
  - count_o = previous count + accepted pushes − pop; range 0..DEPTH.
  - tr_valid_o = (count_o != 0).
- Pointers: wrap modulo DEPTH.
- Full behaviour: a full FIFO with a simultaneous pop accepts exactly one event.
- Disabled capture: en_i = 0 suppresses capture only. Draining and the counter continue.
- Reset mid-operation: all state is cleared immediately. No partial entry survives.

Test Plan:
- Reset; at counter = 3, rf_we_i = 1, rf_addr_i = 8, rf_data_i = 0x1234 → next cycle: tr_valid_o = 1, kind = 0, addr = 8, data = 0x1234, cycle = 3, count_o = 1.
- rf_we_i = 1, rf_addr_i = 0; then en_i = 0 with dm_we_i = 1 → no entries; count_o stays 0; all tr_* outputs 0.
- Same cycle: RF r2 = 5 and DM addr 0x10 data 7, at counter = 9, ready held 0 → two entries, head kind = 0, addr = 2, data = 5, cycle = 9. After one pop: kind = 1, addr = 0x10, data = 7, cycle = 9.
- Ready held 0; 16 single RF events fill the FIFO (count_o = 16), then one more → count_o stays 16, overflow_o = 1, drop_cnt_o = 1. Pulse clr_i → both 0.
- FIFO full with tr_ready_i = 1 and both events in one cycle → RF accepted, DM dropped, count_o = 16, drop_cnt_o += 1. Drain all 16 → order preserved, final entry is the RF event.
- With 5 entries queued, assert rst_i between clock edges → tr_valid_o = 0, count_o = 0 and all tr_* outputs = 0 immediately. After release, the first stamp is 0.

Source files
------------

// File: rtl/wb_trace_fifo_if.sv
// rtl/wb_trace_fifo_if.sv - capture/drain bundle for the commit-trace FIFO
interface wb_trace_fifo_if #(
  parameter int DEPTH = 16,
  parameter int CYC_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Capture side, fed from the MEM/WB boundary
  logic             en_i;
  logic             clr_i;
  logic             rf_we_i;
  logic [4:0]       rf_addr_i;
  logic [31:0]      rf_data_i;
  logic             dm_we_i;
  logic [31:0]      dm_addr_i;
  logic [31:0]      dm_data_i;

  // Drain side, valid/ready toward the monitor
  logic             tr_valid_o;
  logic             tr_ready_i;
  logic             tr_kind_o;
  logic [31:0]      tr_addr_o;
  logic [31:0]      tr_data_o;
  logic [CYC_W-1:0] tr_cycle_o;

  // Status
  logic [CW-1:0]    count_o;
  logic             overflow_o;
  logic [7:0]       drop_cnt_o;

  modport slave (
    input  en_i, clr_i, rf_we_i, rf_addr_i, rf_data_i,
    input  dm_we_i, dm_addr_i, dm_data_i, tr_ready_i,
    output tr_valid_o, tr_kind_o, tr_addr_o, tr_data_o, tr_cycle_o,
    output count_o, overflow_o, drop_cnt_o
  );

  modport master (
    output en_i, clr_i, rf_we_i, rf_addr_i, rf_data_i,
    output dm_we_i, dm_addr_i, dm_data_i, tr_ready_i,
    input  tr_valid_o, tr_kind_o, tr_addr_o, tr_data_o, tr_cycle_o,
    input  count_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - time-stamped register/memory write trace FIFO
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CYC_W = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  wb_trace_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] W_DEPTH = (CW+1)'(DEPTH);

  // Storage, one field per array so head muxing stays simple
  logic             r_kind  [DEPTH];
  logic [31:0]      r_addr  [DEPTH];
  logic [31:0]      r_data  [DEPTH];
  logic [CYC_W-1:0] r_stamp [DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CYC_W-1:0] r_cyc;
  logic             r_ovf;
  logic [7:0]       r_drop;

  logic             w_valid;
  logic             w_pop;
  logic             w_rf_ev;
  logic             w_dm_ev;
  logic [CW:0]      w_free;
  logic             w_rf_acc;
  logic             w_dm_acc;
  logic [AW-1:0]    w_dm_ptr;
  logic [1:0]       w_n_push;
  logic [1:0]       w_n_drop;
  logic [8:0]       w_drop_sum;

  // Event qualification and slot allocation; a pop frees a slot in the same cycle
  always_comb begin
    w_valid    = (r_count != '0);
    w_pop      = w_valid & bus.tr_ready_i;
    w_rf_ev    = bus.en_i & bus.rf_we_i & (bus.rf_addr_i != 5'd0);
    w_dm_ev    = bus.en_i & bus.dm_we_i;
    w_free     = W_DEPTH - {1'b0, r_count} + (CW+1)'(w_pop);
    // RF is the older instruction, so it claims the first free slot
    w_rf_acc   = w_rf_ev & (w_free != '0);
    w_dm_acc   = w_dm_ev & (w_free > (CW+1)'(w_rf_acc));
    w_dm_ptr   = r_wr_ptr + AW'(w_rf_acc);
    w_n_push   = {1'b0, w_rf_acc} + {1'b0, w_dm_acc};
    w_n_drop   = {1'b0, w_rf_ev & ~w_rf_acc} + {1'b0, w_dm_ev & ~w_dm_acc};
    w_drop_sum = {1'b0, r_drop} + 9'(w_n_drop);
  end

  // Entry storage; RF and DM may both land in one cycle at consecutive slots
  always_ff @(posedge clk_i) begin
    if (w_rf_acc) begin
      r_kind[r_wr_ptr]  <= 1'b0;
      r_addr[r_wr_ptr]  <= {27'd0, bus.rf_addr_i};
      r_data[r_wr_ptr]  <= bus.rf_data_i;
      r_stamp[r_wr_ptr] <= r_cyc;
    end
    if (w_dm_acc) begin
      r_kind[w_dm_ptr]  <= 1'b1;
      r_addr[w_dm_ptr]  <= bus.dm_addr_i;
      r_data[w_dm_ptr]  <= bus.dm_data_i;
      r_stamp[w_dm_ptr] <= r_cyc;
    end
  end

  // Pointers, occupancy and the free-running stamp counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_cyc    <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(w_n_push) - CW'(w_pop);
      r_cyc    <= r_cyc + 1'b1;
    end
  end

  // Drop bookkeeping; a drop in the clear cycle overrides the clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovf  <= 1'b0;
      r_drop <= 8'd0;
    end else if (bus.clr_i) begin
      r_ovf  <= (w_n_drop != 2'd0);
      r_drop <= 8'(w_n_drop);
    end else begin
      if (w_n_drop != 2'd0) r_ovf <= 1'b1;
      r_drop <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
    end
  end

  // First-word-fall-through head; fields forced to zero while empty
  always_comb begin
    bus.tr_valid_o = w_valid;
    bus.tr_kind_o  = 1'b0;
    bus.tr_addr_o  = 32'd0;
    bus.tr_data_o  = 32'd0;
    bus.tr_cycle_o = '0;
    if (w_valid) begin
      bus.tr_kind_o  = r_kind[r_rd_ptr];
      bus.tr_addr_o  = r_addr[r_rd_ptr];
      bus.tr_data_o  = r_data[r_rd_ptr];
      bus.tr_cycle_o = r_stamp[r_rd_ptr];
    end
    bus.count_o    = r_count;
    bus.overflow_o = r_ovf;
    bus.drop_cnt_o = r_drop;
  end
endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb/tb_wb_trace_fifo.sv - self-checking bench for wb_trace_fifo
module tb_wb_trace_fifo;
  localparam int DEPTH = 16;
  localparam int CYC_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  wb_trace_fifo_if #(.DEPTH(DEPTH), .CYC_W(CYC_W)) tif ();

  wb_trace_fifo #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (tif.slave)
  );

  typedef struct {
    bit        kind;
    bit [31:0] addr;
    bit [31:0] data;
    bit [15:0] cyc;
  } ent_t;

  ent_t      m_q[$];
  bit [15:0] m_cyc;
  bit        m_ovf;
  int        m_drop;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of entries, updated from the inputs seen at each edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_cyc  = 0;
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      int   nd;
      ent_t e;
      nd = 0;
      if (m_q.size() > 0 && tif.tr_ready_i) void'(m_q.pop_front());
      if (tif.en_i && tif.rf_we_i && tif.rf_addr_i != 0) begin
        e.kind = 0; e.addr = {27'd0, tif.rf_addr_i}; e.data = tif.rf_data_i; e.cyc = m_cyc;
        if (m_q.size() < DEPTH) m_q.push_back(e); else nd++;
      end
      if (tif.en_i && tif.dm_we_i) begin
        e.kind = 1; e.addr = tif.dm_addr_i; e.data = tif.dm_data_i; e.cyc = m_cyc;
        if (m_q.size() < DEPTH) m_q.push_back(e); else nd++;
      end
      if (tif.clr_i) begin
        m_ovf  = (nd > 0);
        m_drop = nd;
      end else begin
        if (nd > 0) m_ovf = 1;
        m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
      end
      m_cyc = m_cyc + 16'd1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      bit   v;
      ent_t h;
      v = (m_q.size() > 0);
      h = '{0, 0, 0, 0};
      if (v) h = m_q[0];
      check("valid", tif.tr_valid_o, v);
      check("kind",  tif.tr_kind_o,  h.kind);
      check("addr",  tif.tr_addr_o,  h.addr);
      check("data",  tif.tr_data_o,  h.data);
      check("cycle", tif.tr_cycle_o, h.cyc);
      check("count", tif.count_o,    m_q.size());
      check("ovf",   tif.overflow_o, m_ovf);
      check("drop",  tif.drop_cnt_o, m_drop);
    end
  end

  task automatic step(input bit rfw, input bit [4:0] ra, input bit [31:0] rd,
                      input bit dmw, input bit [31:0] da, input bit [31:0] dd,
                      input bit rdy, input bit en = 1'b1, input bit clr = 1'b0);
    tif.rf_we_i    = rfw;
    tif.rf_addr_i  = ra;
    tif.rf_data_i  = rd;
    tif.dm_we_i    = dmw;
    tif.dm_addr_i  = da;
    tif.dm_data_i  = dd;
    tif.tr_ready_i = rdy;
    tif.en_i       = en;
    tif.clr_i      = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy = 1'b0);
    step(0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, tif.tr_valid_o, 0);
    check({tag, "_kind"},  tif.tr_kind_o,  0);
    check({tag, "_addr"},  tif.tr_addr_o,  0);
    check({tag, "_data"},  tif.tr_data_o,  0);
    check({tag, "_cycle"}, tif.tr_cycle_o, 0);
    check({tag, "_count"}, tif.count_o,    0);
  endtask

  initial begin
    tif.en_i = 0; tif.clr_i = 0; tif.rf_we_i = 0; tif.rf_addr_i = 0; tif.rf_data_i = 0;
    tif.dm_we_i = 0; tif.dm_addr_i = 0; tif.dm_data_i = 0; tif.tr_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check_empty("rst");
    check("rst_ovf",  tif.overflow_o, 0);
    check("rst_drop", tif.drop_cnt_o, 0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Single RF write stamped 3
    repeat (3) idle();
    step(1, 5'd8, 32'h1234, 0, 0, 0, 0);
    check("t1_valid", tif.tr_valid_o, 1);
    check("t1_kind",  tif.tr_kind_o,  0);
    check("t1_addr",  tif.tr_addr_o,  8);
    check("t1_data",  tif.tr_data_o,  32'h1234);
    check("t1_cycle", tif.tr_cycle_o, 3);
    check("t1_count", tif.count_o,    1);
    idle(1);

    // r0 write and disabled capture produce nothing
    step(1, 5'd0, 32'hdead, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h20, 32'h99, 0, 1'b0);
    check_empty("t2");

    // Simultaneous RF + DM at stamp 9
    while (m_cyc != 16'd9) idle();
    step(1, 5'd2, 32'd5, 1, 32'h10, 32'd7, 0);
    check("t3_count", tif.count_o,    2);
    check("t3_kind0", tif.tr_kind_o,  0);
    check("t3_addr0", tif.tr_addr_o,  2);
    check("t3_data0", tif.tr_data_o,  5);
    check("t3_cyc0",  tif.tr_cycle_o, 9);
    idle(1);
    check("t3_kind1", tif.tr_kind_o,  1);
    check("t3_addr1", tif.tr_addr_o,  32'h10);
    check("t3_data1", tif.tr_data_o,  7);
    check("t3_cyc1",  tif.tr_cycle_o, 9);
    idle(1);

    // Fill, overflow, clear, and clear colliding with a drop
    for (int i = 0; i < DEPTH; i++) step(1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 0);
    check("t4_full", tif.count_o, 16);
    step(1, 5'd17, 32'h777, 0, 0, 0, 0);
    check("t4_count", tif.count_o,    16);
    check("t4_ovf",   tif.overflow_o, 1);
    check("t4_drop",  tif.drop_cnt_o, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    check("t4_clr_ovf",  tif.overflow_o, 0);
    check("t4_clr_drop", tif.drop_cnt_o, 0);
    step(1, 5'd18, 32'h888, 0, 0, 0, 0, 1'b1, 1'b1);
    check("t4_cd_ovf",  tif.overflow_o, 1);
    check("t4_cd_drop", tif.drop_cnt_o, 1);
    repeat (130) step(1, 5'd19, 32'h1, 1, 32'h4, 32'h2, 0);
    check("t4_sat", tif.drop_cnt_o, 255);
    step(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    check("t4_clr2", tif.drop_cnt_o, 0);

    // Full with pop and two events: one accepted, one dropped
    step(1, 5'd30, 32'hbeef, 1, 32'h40, 32'hcafe, 1);
    check("t5_count", tif.count_o,    16);
    check("t5_drop",  tif.drop_cnt_o, 1);
    check("t5_ovf",   tif.overflow_o, 1);
    repeat (15) idle(1);
    check("t5_last_count", tif.count_o,   1);
    check("t5_last_kind",  tif.tr_kind_o, 0);
    check("t5_last_addr",  tif.tr_addr_o, 30);
    check("t5_last_data",  tif.tr_data_o, 32'hbeef);
    idle(1);
    check_empty("t5_drained");

    // Asynchronous reset with entries queued
    for (int i = 0; i < 5; i++) step(1, 5'(i + 1), 32'h50 + 32'(i), 0, 0, 0, 0);
    check("t6_pre", tif.count_o, 5);
    #3;
    rst = 1'b1;
    #1;
    check_empty("t6_rst");
    check("t6_ovf",  tif.overflow_o, 0);
    check("t6_drop", tif.drop_cnt_o, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(1, 5'd3, 32'h33, 0, 0, 0, 0);
    check("t6_cycle", tif.tr_cycle_o, 0);
    check("t6_count", tif.count_o,    1);
    check("t6_data",  tif.tr_data_o,  32'h33);
    repeat (3) idle(1);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
